// File: rtl/expr_pkg.sv
// Shared types and constants for the expression stream checker.
// Optional macro EXPR_PAREN_EN adds the CLOSE state (parenthesis support).
package expr_pkg;

    // FSM states. CLOSE exists only when parentheses are enabled.
    typedef enum logic [2:0] {
        IDLE,
        NUM,
        OPW,
`ifdef EXPR_PAREN_EN
        CLOSE,
`endif
        ERR
    } state_t;

    // Character classes produced by expr_char_class.
    typedef enum logic [2:0] {
        C_DIG,
        C_OP,
        C_LP,
        C_RP,
        C_OTHER
    } char_class_t;

    // ASCII codes used by the recogniser.
    localparam logic [7:0] CH_0     = 8'd48;
    localparam logic [7:0] CH_9     = 8'd57;
    localparam logic [7:0] CH_PLUS  = 8'd43;
    localparam logic [7:0] CH_MINUS = 8'd45;
    localparam logic [7:0] CH_MUL   = 8'd42;
    localparam logic [7:0] CH_DIV   = 8'd47;
    localparam logic [7:0] CH_LP    = 8'd40;
    localparam logic [7:0] CH_RP    = 8'd41;

endpackage

// File: rtl/expr_char_class.sv
// Combinational character classifier for the expression checker.
// Without EXPR_PAREN_EN, '(' and ')' classify as C_OTHER.
module expr_char_class
    import expr_pkg::*;
(
    input  logic [7:0]  in,
    output char_class_t cls,
    output logic        is_zero
);

    // Map one ASCII byte to its grammar class.
    // NOTE: every output gets a default first so no path can infer a latch.
    always_comb begin
        cls     = C_OTHER;
        is_zero = (in == CH_0);
        if (in >= CH_0 && in <= CH_9) begin
            cls = C_DIG;
        end else if (in == CH_PLUS || in == CH_MINUS || in == CH_MUL || in == CH_DIV) begin
            cls = C_OP;
        end
`ifdef EXPR_PAREN_EN
        else if (in == CH_LP) begin
            cls = C_LP;
        end else if (in == CH_RP) begin
            cls = C_RP;
        end
`endif
    end

endmodule

// File: rtl/expr_stream_checker.sv
// Streaming recogniser for number (op number)* with bounded digits and terms.
// out = prefix so far is a complete expression; err = sticky, cleared by
// clr or restart. Optional macro EXPR_PAREN_EN adds nested parentheses.
module expr_stream_checker
    import expr_pkg::*;
#(
    parameter int MAX_DIGITS = 4,
    parameter int MAX_TERMS  = 8,
    parameter int MAX_DEPTH  = 4
) (
    input  logic                           clk,
    input  logic                           clr,
    input  logic [7:0]                     in,
    input  logic                           in_valid,
    input  logic                           restart,
    output logic                           out,
    output logic                           err,
    output logic [$clog2(MAX_TERMS+1)-1:0] term_cnt,
    output logic [$clog2(MAX_DEPTH+1)-1:0] depth
);

    localparam int TW  = $clog2(MAX_TERMS + 1);
    localparam int DCW = $clog2(MAX_DIGITS + 1);

    char_class_t    cls;
    logic           is_zero;

    state_t         state_q, state_d;
    logic [DCW-1:0] digit_q, digit_d;
    logic [TW-1:0]  term_q, term_d;
    logic           lz_q, lz_d;
    logic           out_q, out_d;
    logic           err_q, err_d;
    logic           depth_zero;
    logic           to_err;

    expr_char_class u_class (
        .in      (in),
        .cls     (cls),
        .is_zero (is_zero)
    );

`ifdef EXPR_PAREN_EN
    localparam int DW = $clog2(MAX_DEPTH + 1);
    logic [DW-1:0] depth_q, depth_d;
    assign depth_zero = (depth_q == '0);
    assign depth      = depth_q;
`else
    assign depth_zero = 1'b1;
    assign depth      = '0;
`endif

    assign out      = out_q;
    assign err      = err_q;
    assign term_cnt = term_q;

    // Next-state and next-output decode for one consumed character.
    always_comb begin
        state_d = state_q;
        digit_d = digit_q;
        term_d  = term_q;
        lz_d    = lz_q;
        out_d   = out_q;
        err_d   = err_q;
`ifdef EXPR_PAREN_EN
        depth_d = depth_q;
`endif
        to_err  = 1'b0;

        if (restart) begin
            state_d = IDLE;
            digit_d = '0;
            term_d  = '0;
            lz_d    = 1'b0;
            out_d   = 1'b0;
            err_d   = 1'b0;
`ifdef EXPR_PAREN_EN
            depth_d = '0;
`endif
        end else if (in_valid) begin
            case (state_q)
                // IDLE is only reached with term_q==0, so +1 yields 1 there.
                IDLE, OPW: begin
                    case (cls)
                        C_DIG: begin
                            state_d = NUM;
                            digit_d = DCW'(1);
                            term_d  = term_q + 1'b1;
                            lz_d    = is_zero;
                            out_d   = depth_zero;
                        end
`ifdef EXPR_PAREN_EN
                        C_LP: begin
                            if (depth_q == DW'(MAX_DEPTH)) begin
                                to_err = 1'b1;
                            end else begin
                                depth_d = depth_q + 1'b1;
                                state_d = OPW;
                                out_d   = 1'b0;
                            end
                        end
`endif
                        default: to_err = 1'b1;
                    endcase
                end

`ifdef EXPR_PAREN_EN
                NUM, CLOSE: begin
`else
                NUM: begin
`endif
                    if (cls == C_DIG && state_q == NUM) begin
                        if (lz_q || digit_q == DCW'(MAX_DIGITS)) begin
                            to_err = 1'b1;
                        end else begin
                            digit_d = digit_q + 1'b1;
                        end
                    end else if (cls == C_OP) begin
                        if (term_q == TW'(MAX_TERMS)) begin
                            to_err = 1'b1;
                        end else begin
                            state_d = OPW;
                            out_d   = 1'b0;
                        end
                    end
`ifdef EXPR_PAREN_EN
                    else if (cls == C_RP) begin
                        if (depth_q == '0) begin
                            to_err = 1'b1;
                        end else begin
                            depth_d = depth_q - 1'b1;
                            state_d = CLOSE;
                            out_d   = (depth_q == DW'(1));
                        end
                    end
`endif
                    else begin
                        to_err = 1'b1;
                    end
                end

                ERR: begin
                    // Absorb everything; only clr or restart leave ERR.
                end

                default: to_err = 1'b1;
            endcase

            if (to_err) begin
                state_d = ERR;
                err_d   = 1'b1;
                out_d   = 1'b0;
            end
        end
    end

    // State and counter registers with asynchronous active-low clear.
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= IDLE;
            digit_q <= '0;
            term_q  <= '0;
            lz_q    <= 1'b0;
            out_q   <= 1'b0;
            err_q   <= 1'b0;
`ifdef EXPR_PAREN_EN
            depth_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            digit_q <= digit_d;
            term_q  <= term_d;
            lz_q    <= lz_d;
            out_q   <= out_d;
            err_q   <= err_d;
`ifdef EXPR_PAREN_EN
            depth_q <= depth_d;
`endif
        end
    end

endmodule

// File: tb/tb_expr_stream_checker.sv
// Self-checking bench for expr_stream_checker: a table of directed vectors,
// hand-written corner sequences and a randomized run against a prefix-parsing
// reference model. Three instances share the stimulus with different limits.
module tb_expr_stream_checker;

`ifdef EXPR_PAREN_EN
    localparam bit PAREN = 1'b1;
`else
    localparam bit PAREN = 1'b0;
`endif

    // Limits per instance: d0 default, d1 MAX_TERMS=2, d2 MAX_DEPTH=2.
    localparam int MDIG [3] = '{4, 4, 4};
    localparam int MTRM [3] = '{8, 2, 8};
    localparam int MDEP [3] = '{4, 4, 2};

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] ch = 8'd0;
    logic       in_valid = 1'b0;
    logic       restart = 1'b0;

    logic o0, e0, o1, e1, o2, e2;
    logic [3:0] t0;
    logic [1:0] t1;
    logic [3:0] t2;
    logic [2:0] dp0;
    logic [2:0] dp1;
    logic [1:0] dp2;

    int checks = 0;
    int failures = 0;

    bit [7:0] stream[$];

    always #5 clk = ~clk;

    expr_stream_checker #(.MAX_DIGITS(4), .MAX_TERMS(8), .MAX_DEPTH(4)) d0 (
        .clk(clk), .clr(clr), .in(ch), .in_valid(in_valid), .restart(restart),
        .out(o0), .err(e0), .term_cnt(t0), .depth(dp0));

    expr_stream_checker #(.MAX_DIGITS(4), .MAX_TERMS(2), .MAX_DEPTH(4)) d1 (
        .clk(clk), .clr(clr), .in(ch), .in_valid(in_valid), .restart(restart),
        .out(o1), .err(e1), .term_cnt(t1), .depth(dp1));

    expr_stream_checker #(.MAX_DIGITS(4), .MAX_TERMS(8), .MAX_DEPTH(2)) d2 (
        .clk(clk), .clr(clr), .in(ch), .in_valid(in_valid), .restart(restart),
        .out(o2), .err(e2), .term_cnt(t2), .depth(dp2));

    typedef struct packed {
        bit ok;
        bit complete;
        int terms;
        int depth;
    } eval_t;

    typedef struct {
        bit       rs;
        bit       v;
        bit [7:0] c;
        bit       e_out;
        bit       e_err;
        int       e_term;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference: scan the whole accepted prefix token by token. Counts stop
    // at the first illegal character, which is where the sticky error begins.
    function automatic eval_t eval_prefix(input bit [7:0] q[$], input int maxd,
                                          input int maxt, input int maxdep);
        eval_t r;
        int ndig = 0;
        bit [7:0] first = 8'd0;
        int prev = 0; // 0 none, 1 digit, 2 op, 3 '(', 4 ')'
        bit [7:0] c;
        r.ok = 1'b1;
        r.complete = 1'b0;
        r.terms = 0;
        r.depth = 0;
        foreach (q[i]) begin
            c = q[i];
            if (c >= 8'd48 && c <= 8'd57) begin
                if (prev == 1) begin
                    if (first == 8'd48 || ndig >= maxd) r.ok = 1'b0;
                    else ndig++;
                end else if (prev == 4) begin
                    r.ok = 1'b0;
                end else begin
                    ndig = 1;
                    first = c;
                    r.terms++;
                    prev = 1;
                end
            end else if (c == 8'd42 || c == 8'd43 || c == 8'd45 || c == 8'd47) begin
                if ((prev == 1 || prev == 4) && r.terms < maxt) prev = 2;
                else r.ok = 1'b0;
            end else if (PAREN && c == 8'd40) begin
                if ((prev == 0 || prev == 2 || prev == 3) && r.depth < maxdep) begin
                    r.depth++;
                    prev = 3;
                end else r.ok = 1'b0;
            end else if (PAREN && c == 8'd41) begin
                if ((prev == 1 || prev == 4) && r.depth > 0) begin
                    r.depth--;
                    prev = 4;
                end else r.ok = 1'b0;
            end else begin
                r.ok = 1'b0;
            end
            if (!r.ok) break;
        end
        r.complete = (prev == 1 || prev == 4) && r.depth == 0;
        return r;
    endfunction

    task automatic check_models(input string tag);
        eval_t r;
        logic [31:0] ao, ae, at, ad;
        for (int i = 0; i < 3; i++) begin
            r = eval_prefix(stream, MDIG[i], MTRM[i], MDEP[i]);
            case (i)
                0: begin ao = 32'(o0); ae = 32'(e0); at = 32'(t0); ad = 32'(dp0); end
                1: begin ao = 32'(o1); ae = 32'(e1); at = 32'(t1); ad = 32'(dp1); end
                default: begin ao = 32'(o2); ae = 32'(e2); at = 32'(t2); ad = 32'(dp2); end
            endcase
            check($sformatf("%s.d%0d.out", tag, i), ao, 32'(r.ok && r.complete));
            check($sformatf("%s.d%0d.err", tag, i), ae, 32'(!r.ok));
            check($sformatf("%s.d%0d.term", tag, i), at, 32'(r.terms));
            check($sformatf("%s.d%0d.depth", tag, i), ad, 32'(r.depth));
        end
    endtask

    // Drive one cycle at posedge+1, sample at the next posedge+1.
    task automatic step(input bit [7:0] c, input bit v, input bit r, input string tag);
        ch = c;
        in_valid = v;
        restart = r;
        @(posedge clk);
        #1;
        if (r) stream.delete();
        else if (v) stream.push_back(c);
        in_valid = 1'b0;
        restart = 1'b0;
        check_models(tag);
    endtask

    task automatic add(input bit rs, input bit v, input bit [7:0] c,
                       input bit e_out, input bit e_err, input int e_term);
        vec_t x;
        x.rs = rs; x.v = v; x.c = c;
        x.e_out = e_out; x.e_err = e_err; x.e_term = e_term;
        vecs.push_back(x);
    endtask

    function automatic bit [7:0] rand_char();
        int k = int'($urandom_range(0, 99));
        if (k < 50) return 8'd48 + 8'($urandom_range(0, 9));
        if (k < 75) begin
            case ($urandom_range(0, 3))
                0: return 8'd43;
                1: return 8'd45;
                2: return 8'd42;
                default: return 8'd47;
            endcase
        end
        if (k < 83) return 8'd40;
        if (k < 91) return 8'd41;
        return 8'($urandom_range(0, 255));
    endfunction

`ifdef EXPR_PAREN_EN
    localparam string PSTR = "(1+2)*3";
    localparam bit    POUT [7] = '{0, 0, 0, 0, 1, 0, 1};
    localparam int    PDEP [7] = '{1, 1, 1, 1, 0, 0, 0};
`endif

    initial begin
        string s;

        // Reset state while clr is held low.
        #12;
        check("reset.out", 32'(o0), 32'd0);
        check("reset.err", 32'(e0), 32'd0);
        check("reset.term", 32'(t0), 32'd0);
        check("reset.depth", 32'(dp0), 32'd0);
        check_models("reset");
        clr = 1'b1;

        // Directed table, expectations for the default-limit instance d0.
        add(1, 0, 8'd0, 0, 0, 0);
        add(0, 1, "1", 1, 0, 1); add(0, 1, "2", 1, 0, 1); add(0, 1, "+", 0, 0, 1);
        add(0, 1, "3", 1, 0, 2); add(0, 1, "*", 0, 0, 2); add(0, 1, "4", 1, 0, 3);
        add(1, 0, 8'd0, 0, 0, 0);
        add(0, 1, "0", 1, 0, 1); add(0, 1, "5", 0, 1, 1); add(0, 1, "7", 0, 1, 1);
        add(1, 0, 8'd0, 0, 0, 0); add(0, 1, "7", 1, 0, 1);
        add(1, 0, 8'd0, 0, 0, 0);
        add(0, 1, "1", 1, 0, 1); add(0, 1, "2", 1, 0, 1); add(0, 1, "3", 1, 0, 1);
        add(0, 1, "4", 1, 0, 1); add(0, 1, "5", 0, 1, 1);
        add(1, 0, 8'd0, 0, 0, 0);
        add(0, 1, "1", 1, 0, 1); add(0, 1, "+", 0, 0, 1);
        add(0, 0, "8", 0, 0, 1); add(0, 0, "8", 0, 0, 1); add(0, 0, "8", 0, 0, 1);
        add(0, 1, "2", 1, 0, 2);
        add(1, 1, "9", 0, 0, 0); add(0, 1, "9", 1, 0, 1);
        add(0, 1, "/", 0, 0, 1); add(0, 1, "-", 0, 1, 1);
        add(1, 0, 8'd0, 0, 0, 0); add(0, 1, "a", 0, 1, 0);
        add(1, 0, 8'd0, 0, 0, 0);
        add(0, 1, "0", 1, 0, 1); add(0, 1, "+", 0, 0, 1); add(0, 1, "0", 1, 0, 2);
`ifndef EXPR_PAREN_EN
        add(1, 0, 8'd0, 0, 0, 0); add(0, 1, "(", 0, 1, 0);
`endif
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].c, vecs[i].v, vecs[i].rs, $sformatf("vec%0d", i));
            check($sformatf("vec%0d.out", i), 32'(o0), 32'(vecs[i].e_out));
            check($sformatf("vec%0d.err", i), 32'(e0), 32'(vecs[i].e_err));
            check($sformatf("vec%0d.term", i), 32'(t0), 32'(vecs[i].e_term));
        end

        // Term limit on d1 (MAX_TERMS=2): second '+' errors, count held at 2.
        step(8'd0, 0, 1, "terms");
        s = "1+2+";
        for (int i = 0; i < 4; i++) step(s[i], 1, 0, "terms");
        check("terms.d1.err", 32'(e1), 32'd1);
        check("terms.d1.term", 32'(t1), 32'd2);
        check("terms.d0.err", 32'(e0), 32'd0);

        // Asynchronous clear between clock edges after "12+".
        step(8'd0, 0, 1, "aclr");
        s = "12+";
        for (int i = 0; i < 3; i++) step(s[i], 1, 0, "aclr");
        #2 clr = 1'b0;
        #1;
        stream.delete();
        check("aclr.term", 32'(t0), 32'd0);
        check("aclr.out", 32'(o0), 32'd0);
        check("aclr.err", 32'(e0), 32'd0);
        #1 clr = 1'b1;
        step("3", 1, 0, "aclr.after");
        check("aclr.after.out", 32'(o0), 32'd1);
        check("aclr.after.term", 32'(t0), 32'd1);

`ifdef EXPR_PAREN_EN
        // Parenthesis sequences on d2 (MAX_DEPTH=2).
        step(8'd0, 0, 1, "paren");
        for (int i = 0; i < 7; i++) begin
            step(PSTR[i], 1, 0, "paren");
            check($sformatf("paren%0d.out", i), 32'(o2), 32'(POUT[i]));
            check($sformatf("paren%0d.depth", i), 32'(dp2), 32'(PDEP[i]));
        end
        step(8'd0, 0, 1, "deep");
        for (int i = 0; i < 3; i++) begin
            step("(", 1, 0, "deep");
            check($sformatf("deep%0d.err", i), 32'(e2), 32'(i == 2));
        end
        step(8'd0, 0, 1, "rp");
        step("1", 1, 0, "rp");
        step(")", 1, 0, "rp");
        check("rp.err", 32'(e2), 32'd1);
`endif

        // Randomized run against the reference model.
        step(8'd0, 0, 1, "rand");
        for (int i = 0; i < 400; i++) begin
            step(rand_char(), $urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0,
                 $sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
